// File: rtl/approx_mant_mul_pipe.sv
// Three-stage elastic approximate mantissa multiplier: (1.x)*(1.y) with LP0, LP1 or exact mode,
// normalised to [1,2) with the integer part reported on shift.
module approx_mant_mul_pipe #(
  parameter int WIDTH = 23,
  parameter int TRUNC = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] mantissa_1,
  input  logic [WIDTH-1:0] mantissa_2,
  input  logic [1:0]       mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] mantissa_out,
  output logic [1:0]       shift,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PW = 2*WIDTH + 2;
  localparam logic [WIDTH-1:0] TRUNC_MASK = {WIDTH{1'b1}} << (WIDTH - TRUNC);

  logic             v1, v2, v3;
  logic             en1, en2, en3;
  logic [WIDTH-1:0] x1, y1;
  logic [1:0]       mode1;
  logic [TAG_W-1:0] tag1, tag2, tag3;
  logic [WIDTH:0]   sum2;
  logic [2*WIDTH-1:0] pp2;
  logic [WIDTH-1:0] mant3;
  logic [1:0]       shift3;

  logic [2*WIDTH-1:0] pp_full, pp_trunc, pp_sel;
  logic [PW-1:0]      prod;
  logic [WIDTH-1:0]   mant_n;
  logic [1:0]         shift_n;
  logic               unused_prod_lsbs;

  // Ready chain depends only on stage occupancy and out_ready so bubbles collapse.
  assign en3      = ~v3 | out_ready;
  assign en2      = ~v2 | en3;
  assign en1      = ~v1 | en2;
  assign in_ready = en1;

  always_comb begin
    pp_full  = {{WIDTH{1'b0}}, x1} * {{WIDTH{1'b0}}, y1};
    pp_trunc = {{WIDTH{1'b0}}, x1 & TRUNC_MASK} * {{WIDTH{1'b0}}, y1 & TRUNC_MASK};
    case (mode1)
      2'd0:    pp_sel = '0;
      2'd1:    pp_sel = pp_trunc;
      default: pp_sel = pp_full;
    endcase
  end

  // prod holds 1 + X + Y + partial product with 2 integer and 2*WIDTH fraction bits.
  always_comb begin
    prod = {2'b01, {(2*WIDTH){1'b0}}}
         + {1'b0, sum2, {WIDTH{1'b0}}}
         + {2'b00, pp2};
    shift_n = prod[PW-1:PW-2];
    if (prod[PW-1]) mant_n = prod[2*WIDTH:WIDTH+1];
    else            mant_n = prod[2*WIDTH-1:WIDTH];
  end

  assign unused_prod_lsbs = ^prod[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      x1     <= '0;
      y1     <= '0;
      mode1  <= '0;
      tag1   <= '0;
      sum2   <= '0;
      pp2    <= '0;
      tag2   <= '0;
      mant3  <= '0;
      shift3 <= '0;
      tag3   <= '0;
    end else begin
      if (en1) begin
        v1 <= in_valid;
        if (in_valid) begin
          x1    <= mantissa_1;
          y1    <= mantissa_2;
          mode1 <= mode;
          tag1  <= in_tag;
        end
      end
      if (en2) begin
        v2 <= v1;
        if (v1) begin
          sum2 <= {1'b0, x1} + {1'b0, y1};
          pp2  <= pp_sel;
          tag2 <= tag1;
        end
      end
      if (en3) begin
        v3 <= v2;
        if (v2) begin
          mant3  <= mant_n;
          shift3 <= shift_n;
          tag3   <= tag2;
        end
      end
    end
  end

  assign out_valid    = v3;
  assign mantissa_out = mant3;
  assign shift        = shift3;
  assign out_tag      = tag3;

endmodule

// File: tb/tb_approx_mant_mul_pipe.sv
// Directed and randomised checks for approx_mant_mul_pipe at WIDTH=8, TRUNC=4, TAG_W=4.
module tb_approx_mant_mul_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] m1, m2, mant;
  logic [1:0] mode, shift;
  logic [3:0] in_tag, out_tag;

  int errors = 0;
  int checks = 0;

  approx_mant_mul_pipe #(.WIDTH(8), .TRUNC(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .mantissa_1(m1), .mantissa_2(m2), .mode(mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .mantissa_out(mant), .shift(shift), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  // Golden model: P scaled by 2^16 as a plain integer.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic [1:0] md);
    int unsigned pn, xh, yh;
    xh = x & 8'hF0;
    yh = y & 8'hF0;
    pn = 65536 + (int'(x) + int'(y)) * 256;
    if (md == 2'd1)      pn += xh * yh;
    else if (md >= 2'd2) pn += int'(x) * int'(y);
    if (pn >= 131072) return {pn[17:16], pn[16:9]};
    else              return {pn[17:16], pn[15:8]};
  endfunction

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    m1 = 8'h12; m2 = 8'h34; mode = 2'd2; in_tag = 4'hA;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({out_valid, shift, mant, out_tag} !== 15'd0) begin
        errors++;
        $display("FAIL reset_hold: got valid=%b shift=%b mant=%h tag=%h, want all 0", out_valid, shift, mant, out_tag);
      end
    end
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if ({out_valid, shift, mant, out_tag} !== 15'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got valid=%b shift=%b mant=%h tag=%h ready=%b, want 0s and ready=1",
               out_valid, shift, mant, out_tag, in_ready);
    end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); in_valid = 1'b0; #1;
      checks++;
      if (out_valid !== (i == 3)) begin
        errors++;
        $display("FAIL reset_latency: cycle %0d got out_valid=%b want %b", i, out_valid, i == 3);
      end
    end
    checks++;
    if (shift !== 2'b01 || mant !== 8'h49 || out_tag !== 4'hA) begin
      errors++;
      $display("FAIL reset_first_result: got shift=%b mant=%h tag=%h, want 01 49 a", shift, mant, out_tag);
    end
  endtask

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [1:0] md;
    logic [1:0] sh;
    logic [7:0] m;
  } vec_t;

  task automatic test_vectors;
    vec_t vecs [11];
    vecs = '{
      '{8'h80, 8'h80, 2'd0, 2'b10, 8'h00},
      '{8'h80, 8'h80, 2'd1, 2'b10, 8'h20},
      '{8'h80, 8'h80, 2'd2, 2'b10, 8'h20},
      '{8'h40, 8'h20, 2'd0, 2'b01, 8'h60},
      '{8'h40, 8'h20, 2'd1, 2'b01, 8'h68},
      '{8'h40, 8'h20, 2'd2, 2'b01, 8'h68},
      '{8'h40, 8'h20, 2'd3, 2'b01, 8'h68},
      '{8'hFF, 8'hFF, 2'd0, 2'b10, 8'h7F},
      '{8'hFF, 8'hFF, 2'd2, 2'b11, 8'hFE},
      '{8'hFF, 8'hFF, 2'd1, 2'b11, 8'hEF},
      '{8'h00, 8'h00, 2'd2, 2'b01, 8'h00}
    };
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (i < 11) begin
        in_valid = 1'b1; m1 = vecs[i].x; m2 = vecs[i].y; mode = vecs[i].md; in_tag = 4'(i);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i < 11) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL vec_in_ready: vector %0d got in_ready=%b want 1", i, in_ready);
        end
      end
      if (i >= 3) begin
        checks++;
        if (out_valid !== 1'b1 || shift !== vecs[i-3].sh || mant !== vecs[i-3].m || out_tag !== 4'(i-3)) begin
          errors++;
          $display("FAIL vec_result: vector %0d got v=%b shift=%b mant=%h tag=%h, want 1 %b %h %h",
                   i-3, out_valid, shift, mant, out_tag, vecs[i-3].sh, vecs[i-3].m, 4'(i-3));
        end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [13:0] q[$];
    logic [13:0] exp_v, prev;
    int sent = 0, recv = 0, occ = 0, cyc = 0;
    bit prev_stall = 0;
    while (recv < 8 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      in_valid  = (sent < 8);
      m1        = 8'(sent * 8'h1D + 8'h31);
      m2        = 8'(sent * 8'h47 + 8'h05);
      mode      = 2'(sent % 4);
      in_tag    = 4'(sent);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (in_ready !== !(occ == 3 && !out_ready)) begin
        errors++;
        $display("FAIL bp_in_ready: got %b want %b (occupancy %0d out_ready %b)", in_ready, !(occ == 3 && !out_ready), occ, out_ready);
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || {out_tag, shift, mant} !== prev) begin
          errors++;
          $display("FAIL bp_stall_hold: got v=%b %h want 1 %h", out_valid, {out_tag, shift, mant}, prev);
        end
      end
      if (out_valid && out_ready) begin
        exp_v = (q.size() > 0) ? q.pop_front() : 14'h3FFF;
        checks++;
        if ({out_tag, shift, mant} !== exp_v || out_tag !== 4'(recv)) begin
          errors++;
          $display("FAIL bp_result: got tag=%h shift=%b mant=%h want %h", out_tag, shift, mant, exp_v);
        end
        recv++; occ--;
      end
      if (in_valid && in_ready) begin
        q.push_back({in_tag, model(m1, m2, mode)});
        sent++; occ++;
      end
      prev_stall = out_valid && !out_ready;
      prev = {out_tag, shift, mant};
    end
    in_valid = 1'b0;
    checks++;
    if (recv != 8) begin
      errors++;
      $display("FAIL bp_count: got %0d results want 8", recv);
    end
  endtask

  task automatic test_random(input int n);
    logic [13:0] q[$];
    logic [13:0] exp_v, prev;
    int sent = 0, cyc = 0;
    bit prev_stall = 0, did_rst = 0, just_rst = 0;
    while ((sent < n || q.size() > 0) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (!did_rst && sent == n/2) begin
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'($urandom_range(0, 1));
        did_rst = 1; just_rst = 1;
        q.delete(); prev_stall = 0;
        @(negedge clk);
        cyc++;
        rst = 1'b0;
      end
      in_valid  = (sent < n) && ($urandom_range(0, 9) < 7);
      m1        = 8'($urandom);
      m2        = 8'($urandom);
      mode      = 2'($urandom);
      in_tag    = 4'(sent);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (just_rst) begin
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
          errors++;
          $display("FAIL rnd_reset_flush: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        just_rst = 0;
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || {out_tag, shift, mant} !== prev) begin
          errors++;
          $display("FAIL rnd_stall_hold: got v=%b %h want 1 %h", out_valid, {out_tag, shift, mant}, prev);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rnd_spurious: unexpected result tag=%h shift=%b mant=%h", out_tag, shift, mant);
        end else begin
          exp_v = q.pop_front();
          if ({out_tag, shift, mant} !== exp_v) begin
            errors++;
            $display("FAIL rnd_result: got %h want %h", {out_tag, shift, mant}, exp_v);
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back({in_tag, model(m1, m2, mode)});
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      prev = {out_tag, shift, mant};
    end
    in_valid = 1'b0;
    checks++;
    if (sent < n || q.size() != 0) begin
      errors++;
      $display("FAIL rnd_timeout: sent %0d of %0d, %0d results outstanding", sent, n, q.size());
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    m1 = '0; m2 = '0; mode = '0; in_tag = '0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_random(10000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/approx_mant_mul_pipe.md
Name: approx_mant_mul_pipe

Overview:
- Pipelined, parametrised successor to the level-0 combinational approximate mantissa multiplier in the ApproxLP family.
- Multiplies two hidden-one mantissas (1.x)·(1.y) with a per-transaction approximation mode: LP0 sum-only, LP1 truncated partial product, or exact.
- Normalises the result and returns the integer part as a shift indication.
- Sits between exponent/sign handling and FP result packing. Uses a valid/ready elastic 3-stage pipeline with a passthrough tag.

Parameters:
- WIDTH, 23, mantissa fraction width (hidden one excluded); legal range 4..52.
- TRUNC, 8, number of top fraction bits of each operand used by the LP1 partial product; legal range 1..WIDTH.
- TAG_W, 4, width of the sideband tag carried alongside each transaction.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept an input this cycle.
- mantissa_1  in  WIDTH  operand x fraction.
- mantissa_2  in  WIDTH  operand y fraction.
- mode  in  2  0=LP0, 1=LP1, 2=exact, 3=reserved (treated as exact).
- in_tag  in  TAG_W  sideband tag, passed through unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- mantissa_out  out  WIDTH  normalised product fraction.
- shift  out  2  integer part of the product before normalisation: 2'b01 means [1,2), 2'b10 or 2'b11 means [2,4).
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset: all stage valid bits cleared; out_valid=0; mantissa_out, shift and out_tag all 0. Reset mid-operation flushes every in-flight transaction, and nothing is emitted for them. in_ready=1 in the first cycle after reset is released.
- Fixed-point arithmetic: X=x/2^WIDTH and Y=y/2^WIDTH. Internal precision is 2 integer bits and 2·WIDTH fraction bits; no rounding anywhere.
- Product P by mode:
  - LP0: P = 1 + X + Y.
  - LP1: P = 1 + X + Y + Xh·Yh, where Xh and Yh are the top TRUNC bits of x and y at their original weights (lower bits zeroed).
  - Exact (mode 2 or 3): P = (1+X)(1+Y) = 1 + X + Y + X·Y.
- P always satisfies 1 <= P < 4.
- Output fields:
  - shift = floor(P), 2 bits.
  - If P >= 2: mantissa_out = floor(frac(P/2)·2^WIDTH).
  - Otherwise: mantissa_out = floor(frac(P)·2^WIDTH), i.e. truncate.
- Pipeline stages:
  - S1 registers the operands, mode and tag.
  - S2 registers the sum X+Y and the mode-selected partial product.
  - S3 registers the normalised result.
- Latency: exactly 3 cycles from the input handshake (in_valid&in_ready) to out_valid when unstalled. Throughput is 1 transaction per cycle.
- Stage enables: en3 = ~v3 | out_ready; en2 = ~v2 | en3; en1 = ~v1 | en2; in_ready = en1. The ready chain is combinational and is a function of valid bits and out_ready only, never of in_valid.
- Stage loading: stage k loads when en_k is high. Its valid bit takes the upstream valid (in_valid for S1). A bubble in any stage is collapsed when downstream stalls.
- Stall: while out_valid=1 and out_ready=0, mantissa_out, shift and out_tag hold stable. No transaction is dropped or duplicated.
- Ordering: results leave strictly in acceptance order, and the tag always stays with its own data.
- Mode is sampled per transaction at acceptance. Mixed modes back-to-back are legal.
- Simultaneous input accept and output drain with a full pipeline: both happen and occupancy stays at 3.

Test Plan (WIDTH=8, TRUNC=4, TAG_W=4):
- Reset check: assert rst for 2 cycles with in_valid=1 -> out_valid=0 and all outputs 0 during and 1 cycle after; first accepted input appears exactly 3 cycles after its handshake.
- x=0x80, y=0x80:
  - mode 0 -> shift=2'b10, mantissa_out=0x00.
  - mode 1 -> shift=2'b10, mantissa_out=0x20.
  - mode 2 -> shift=2'b10, mantissa_out=0x20.
- x=0x40, y=0x20:
  - mode 0 -> shift=2'b01, mantissa_out=0x60.
  - mode 1 -> shift=2'b01, mantissa_out=0x68.
  - mode 2 -> shift=2'b01, mantissa_out=0x68.
  - mode 3 -> same as mode 2.
- x=0xFF, y=0xFF:
  - mode 0 -> shift=2'b10, mantissa_out=0x7F.
  - mode 2 -> shift=2'b11, mantissa_out=0xFE.
- Backpressure: stream 8 tagged inputs (tags 0..7) with out_ready toggling with a random pattern (~50%) -> all 8 results emitted in tag order, outputs stable while stalled, in_ready=0 only when all 3 stages are full and out_ready=0.
- Random sweep: 10k random x, y and mode with random in_valid/out_ready -> every result matches the golden model; assert rst mid-stream -> in-flight transactions vanish with no spurious out_valid.
